// File: rtl/wbs_ram16_pkg.sv
// Shared limits, lane-select codes and bus widths for the wbs_ram16 slave.
// No logic; imported by the memory and the handshake/pipeline modules.
package wbs_ram16_pkg;

    localparam int LATENCY_MIN     = 1;
    localparam int LATENCY_MAX     = 4;
    localparam int WAIT_STATES_MIN = 0;
    localparam int WAIT_STATES_MAX = 7;
    localparam int WS_CNT_W        = $clog2(WAIT_STATES_MAX + 1);

    localparam int ADR_W = 64;
    localparam int DAT_W = 16;

    localparam logic [1:0] SEL_LO = 2'b01;
    localparam logic [1:0] SEL_HI = 2'b10;
    localparam logic [1:0] SEL_HW = 2'b11;

    // One slot of the response pipeline.
    typedef struct packed {
        logic             vld;
        logic             err;
        logic             rd;
        logic [DAT_W-1:0] dat;
    } stage_t;

endpackage

// File: rtl/wbs_ram16_mem.sv
// 2**ADDR_W x 16 RAM: synchronous byte-lane writes, combinational read.
// Zero latency on the read port; no flow control (caller gates we_i).
// Contents are never reset.
module wbs_ram16_mem
    import wbs_ram16_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [1:0]        sel_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DAT_W-1:0]  wdat_i,
    output logic [DAT_W-1:0]  rdat_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] lo_q [DEPTH];
    logic [7:0] hi_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i && ((sel_i & SEL_LO) != 2'b00)) begin
            lo_q[adr_i] <= wdat_i[7:0];
        end
        if (we_i && ((sel_i & SEL_HI) != 2'b00)) begin
            hi_q[adr_i] <= wdat_i[15:8];
        end
    end

    assign rdat_o = {hi_q[adr_i], lo_q[adr_i]};

endmodule

// File: rtl/wbs_ram16.sv
// Pipelined Wishbone (B.4) slave around a 16-bit RAM; LATENCY edges to ack, in-order responses.
// Backpressure: wbsstall_o held for WAIT_STATES cycles after each accepted request.
// Define WBS_RAM16_ERR_EN to answer out-of-range addresses with wbserr_o instead of aliasing.
module wbs_ram16
    import wbs_ram16_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LATENCY     = 1,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [ADR_W-1:0] wbsadr_i,
    input  logic [DAT_W-1:0] wbsdat_i,
    input  logic             wbswe_i,
    input  logic [1:0]       wbssel_i,
    input  logic             wbsstb_i,
    input  logic             wbscyc_i,
    output logic             wbsstall_o,
    output logic             wbsack_o,
    output logic [DAT_W-1:0] wbsdat_o,
    output logic             wbserr_o
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("wbs_ram16: LATENCY out of range");
    end
    if (WAIT_STATES < WAIT_STATES_MIN || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait
        $error("wbs_ram16: WAIT_STATES out of range");
    end

    logic                accept;
    logic                adr_err;
    logic                mem_we;
    logic [DAT_W-1:0]    mem_rdat;
    logic [WS_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    stage_t              pipe_q [LATENCY];
    stage_t              pipe_d [LATENCY];
    stage_t              last;
    logic [DAT_W-1:0]    rdat_q, rdat_d;

`ifdef WBS_RAM16_ERR_EN
    assign adr_err = (wbsadr_i >> (ADDR_W + 1)) != '0;
    logic unused_adr;
    assign unused_adr = wbsadr_i[0];
`else
    // Upper address bits alias onto the array.
    assign adr_err = 1'b0;
    logic unused_adr;
    assign unused_adr = ^{wbsadr_i[ADR_W-1:ADDR_W+1], wbsadr_i[0]};
`endif

    assign wbsstall_o = (stall_cnt_q != '0);
    assign accept     = wbscyc_i & wbsstb_i & ~wbsstall_o;
    assign mem_we     = accept & wbswe_i & ~adr_err;

    wbs_ram16_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .sel_i  (wbssel_i),
        .adr_i  (wbsadr_i[ADDR_W:1]),
        .wdat_i (wbsdat_i),
        .rdat_o (mem_rdat)
    );

    // Read data is sampled into stage 0 at the acceptance edge, so a write
    // committed on the previous edge is already visible.
    always_comb begin
        pipe_d[0] = '{vld: accept, err: adr_err, rd: ~wbswe_i, dat: mem_rdat};
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (!wbscyc_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i].vld = 1'b0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!wbscyc_i) begin
            stall_cnt_d = '0;
        end else if (accept) begin
            stall_cnt_d = WS_CNT_W'(WAIT_STATES);
        end else if (stall_cnt_q != '0) begin
            stall_cnt_d = stall_cnt_q - WS_CNT_W'(1);
        end
    end

    assign last     = pipe_q[LATENCY-1];
    assign wbsack_o = last.vld & ~last.err;
`ifdef WBS_RAM16_ERR_EN
    assign wbserr_o = last.vld & last.err;
`else
    assign wbserr_o = 1'b0;
`endif

    // Read data appears with its ack and is then held until the next read ack.
    assign wbsdat_o = (wbsack_o & last.rd) ? last.dat : rdat_q;
    assign rdat_d   = wbsdat_o;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_cnt_q <= '0;
            rdat_q      <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            rdat_q      <= rdat_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wbs_ram16.sv
// Bench for wbs_ram16: three instances (L1/W0, L3/W0, L2/W2) against a
// time-slotted response model with directed and random traffic.
module tb_wbs_ram16;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] adr   [NI];
    logic [15:0] wdat  [NI];
    logic        we    [NI];
    logic [1:0]  sel   [NI];
    logic        stb   [NI];
    logic        cyc   [NI];
    logic        stall [NI];
    logic        ack   [NI];
    logic [15:0] rdat  [NI];
    logic        err   [NI];

    wbs_ram16 #(.ADDR_W(10), .LATENCY(1), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .reset_ni(rst_n), .wbsadr_i(adr[0]), .wbsdat_i(wdat[0]),
        .wbswe_i(we[0]), .wbssel_i(sel[0]), .wbsstb_i(stb[0]), .wbscyc_i(cyc[0]),
        .wbsstall_o(stall[0]), .wbsack_o(ack[0]), .wbsdat_o(rdat[0]), .wbserr_o(err[0]));

    wbs_ram16 #(.ADDR_W(10), .LATENCY(3), .WAIT_STATES(0)) u_dut1 (
        .clk_i(clk), .reset_ni(rst_n), .wbsadr_i(adr[1]), .wbsdat_i(wdat[1]),
        .wbswe_i(we[1]), .wbssel_i(sel[1]), .wbsstb_i(stb[1]), .wbscyc_i(cyc[1]),
        .wbsstall_o(stall[1]), .wbsack_o(ack[1]), .wbsdat_o(rdat[1]), .wbserr_o(err[1]));

    wbs_ram16 #(.ADDR_W(10), .LATENCY(2), .WAIT_STATES(2)) u_dut2 (
        .clk_i(clk), .reset_ni(rst_n), .wbsadr_i(adr[2]), .wbsdat_i(wdat[2]),
        .wbswe_i(we[2]), .wbssel_i(sel[2]), .wbsstb_i(stb[2]), .wbscyc_i(cyc[2]),
        .wbsstall_o(stall[2]), .wbsack_o(ack[2]), .wbsdat_o(rdat[2]), .wbserr_o(err[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic int ws_of(input int k);
        return (k == 2) ? 2 : 0;
    endfunction

    // Reference model: memory image plus responses scheduled by due cycle.
    logic [15:0] mem_m       [NI][1024];
    bit          due_vld     [NI][8];
    bit          due_err     [NI][8];
    bit          due_rd      [NI][8];
    logic [15:0] due_dat     [NI][8];
    logic [15:0] exp_dat     [NI];
    int          stall_until [NI];
    bit          accepted    [NI];
    int          acc_cycle   [NI];
    int          ack_cnt     [NI];
    int          err_cnt     [NI];
    int          cyc_n;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 8; j++) due_vld[k][j] = 1'b0;
            stall_until[k] = 0;
            exp_dat[k]     = 16'h0000;
            accepted[k]    = 1'b0;
        end
    endtask

    task automatic model_accept(input int k);
        int idx;
        int slot;
        bit aerr;
        idx = int'((adr[k] >> 1) & 64'h3FF);
`ifdef WBS_RAM16_ERR_EN
        aerr = (adr[k] >> 11) != 64'd0;
`else
        aerr = 1'b0;
`endif
        slot = (cyc_n + lat_of(k)) % 8;
        due_vld[k][slot] = 1'b1;
        due_err[k][slot] = aerr;
        due_rd[k][slot]  = !we[k];
        due_dat[k][slot] = mem_m[k][idx];
        if (we[k] && !aerr) begin
            if (sel[k][0]) mem_m[k][idx][7:0]  = wdat[k][7:0];
            if (sel[k][1]) mem_m[k][idx][15:8] = wdat[k][15:8];
        end
        stall_until[k] = cyc_n + 1 + ws_of(k);
        accepted[k]    = 1'b1;
        acc_cycle[k]   = cyc_n + 1;
    endtask

    // One clock: check every instance at the falling edge, advance the model
    // for the coming rising edge, return 1 time unit after that edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            int s;
            bit e_ack;
            bit e_err;
            bit e_stall;
            s       = cyc_n % 8;
            e_ack   = due_vld[k][s] && !due_err[k][s];
            e_err   = due_vld[k][s] && due_err[k][s];
            if (e_ack && due_rd[k][s]) exp_dat[k] = due_dat[k][s];
            due_vld[k][s] = 1'b0;
            e_stall = (cyc_n < stall_until[k]);
            check($sformatf("ack[%0d]@%0d", k, cyc_n),   64'(ack[k]),   64'(e_ack));
            check($sformatf("err[%0d]@%0d", k, cyc_n),   64'(err[k]),   64'(e_err));
            check($sformatf("stall[%0d]@%0d", k, cyc_n), 64'(stall[k]), 64'(e_stall));
            check($sformatf("dat[%0d]@%0d", k, cyc_n),   64'(rdat[k]),  64'(exp_dat[k]));
            if (ack[k] === 1'b1) ack_cnt[k]++;
            if (err[k] === 1'b1) err_cnt[k]++;
            accepted[k] = 1'b0;
            if (!cyc[k]) begin
                for (int j = 0; j < 8; j++) due_vld[k][j] = 1'b0;
                stall_until[k] = 0;
            end else if (stb[k] && !e_stall) begin
                model_accept(k);
            end
        end
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic issue(input int k, input bit w, input logic [63:0] a,
                         input logic [15:0] d, input logic [1:0] s);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = s;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (accepted[k]) break;
        end
        check($sformatf("accept_in_time[%0d]", k), 64'(accepted[k]), 64'd1);
        stb[k] = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < NI; k++) stb[k] = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int c0;
        int e0;
        int a1;
        int a2;
        logic [63:0] a;

        n_checks = 0; n_pass = 0; cyc_n = 0;
        for (int k = 0; k < NI; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; wdat[k] = '0; sel[k] = '0;
            ack_cnt[k] = 0; err_cnt[k] = 0; acc_cycle[k] = 0;
        end
        model_reset();

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_ack[%0d]", k),   64'(ack[k]),   64'd0);
            check($sformatf("rst_err[%0d]", k),   64'(err[k]),   64'd0);
            check($sformatf("rst_stall[%0d]", k), 64'(stall[k]), 64'd0);
            check($sformatf("rst_dat[%0d]", k),   64'(rdat[k]),  64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain(2);

        // Prefill halfwords 0..15 on every instance.
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 16; i++)
                issue(k, 1'b1, 64'(i * 2), 16'($urandom), 2'b11);
        drain(6);

        // Write then immediate read of the same address.
        c0 = ack_cnt[0];
        issue(0, 1'b1, 64'h10, 16'hBEEF, 2'b11);
        issue(0, 1'b0, 64'h10, 16'h0000, 2'b11);
        drain(2);
        check("beef_dat",  64'(rdat[0]), 64'hBEEF);
        check("beef_acks", 64'(ack_cnt[0] - c0), 64'd2);

        // Byte-lane merging.
        issue(0, 1'b1, 64'h20, 16'h1234, 2'b11);
        issue(0, 1'b1, 64'h20, 16'h5656, 2'b10);
        issue(0, 1'b0, 64'h20, 16'h0000, 2'b00);
        drain(2);
        check("lane_hi", 64'(rdat[0]), 64'h5634);
        issue(0, 1'b1, 64'h20, 16'h7878, 2'b01);
        drain(2);
        check("wr_ack_keeps_dat", 64'(rdat[0]), 64'h5634);
        issue(0, 1'b0, 64'h20, 16'h0000, 2'b01);
        drain(2);
        check("lane_lo", 64'(rdat[0]), 64'h5678);

        // LATENCY=3 back-to-back reads.
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 64'(i * 2), 16'h1000 + 16'(i), 2'b11);
        drain(4);
        c0 = ack_cnt[1];
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 64'(i * 2), 16'h0000, 2'b11);
        drain(6);
        check("l3_acks", 64'(ack_cnt[1] - c0), 64'd4);
        check("l3_last", 64'(rdat[1]), 64'h1003);

        // WAIT_STATES=2 with strobe held.
        c0 = ack_cnt[2];
        issue(2, 1'b0, 64'h0, 16'h0, 2'b11);
        a1 = acc_cycle[2];
        issue(2, 1'b0, 64'h2, 16'h0, 2'b11);
        a2 = acc_cycle[2];
        check("ws_gap1", 64'(a2 - a1), 64'd3);
        issue(2, 1'b0, 64'h4, 16'h0, 2'b11);
        check("ws_gap2", 64'(acc_cycle[2] - a2), 64'd3);
        drain(8);
        check("ws_acks", 64'(ack_cnt[2] - c0), 64'd3);

        // Abandon two in-flight reads by dropping cyc.
        c0 = ack_cnt[1];
        issue(1, 1'b0, 64'h0, 16'h0, 2'b11);
        issue(1, 1'b0, 64'h2, 16'h0, 2'b11);
        cyc[1] = 1'b0;
        drain(6);
        check("abandon_acks", 64'(ack_cnt[1] - c0), 64'd0);
        cyc[1] = 1'b1;

        // Asynchronous reset in the middle of a burst.
        issue(1, 1'b0, 64'h4, 16'h0, 2'b11);
        issue(1, 1'b0, 64'h6, 16'h0, 2'b11);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack",   64'(ack[1]),   64'd0);
        check("mid_rst_stall", 64'(stall[1]), 64'd0);
        check("mid_rst_dat1",  64'(rdat[1]),  64'd0);
        check("mid_rst_dat0",  64'(rdat[0]),  64'd0);
        model_reset();
        for (int k = 0; k < NI; k++) begin cyc[k] = 1'b0; stb[k] = 1'b0; end
        drain(2);
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) cyc[k] = 1'b1;
        c0 = ack_cnt[1];
        drain(5);
        check("post_rst_acks", 64'(ack_cnt[1] - c0), 64'd0);

        // Address above the array.
        issue(0, 1'b1, 64'h0, 16'hA5C3, 2'b11);
        drain(2);
        c0 = ack_cnt[0];
        e0 = err_cnt[0];
        issue(0, 1'b0, 64'h800, 16'h0, 2'b11);
        drain(3);
`ifdef WBS_RAM16_ERR_EN
        check("oob_err",  64'(err_cnt[0] - e0), 64'd1);
        check("oob_ack",  64'(ack_cnt[0] - c0), 64'd0);
        check("oob_dat",  64'(rdat[0]), 64'h0000);
`else
        check("alias_err", 64'(err_cnt[0] - e0), 64'd0);
        check("alias_ack", 64'(ack_cnt[0] - c0), 64'd1);
        check("alias_dat", 64'(rdat[0]), 64'hA5C3);
`endif

        // Random traffic with stall-respecting master and occasional cyc drops.
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < NI; k++) begin
                if (!cyc[k]) begin
                    cyc[k] = 1'b1;
                end else if ($urandom_range(0, 39) == 0) begin
                    cyc[k] = 1'b0;
                    stb[k] = 1'b0;
                end else if (!stb[k] || accepted[k]) begin
                    a = (64'($urandom_range(0, 15)) << 1) | 64'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) a = a | (64'($urandom_range(1, 255)) << 11);
                    if ($urandom_range(0, 15) == 0) a = a | (64'd1 << $urandom_range(11, 63));
                    stb[k]  = ($urandom_range(0, 3) != 0);
                    we[k]   = 1'($urandom_range(0, 1));
                    adr[k]  = a;
                    wdat[k] = 16'($urandom);
                    sel[k]  = 2'($urandom_range(0, 3));
                end
            end
            tick();
        end
        drain(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wbs_ram16.md
WBS_RAM16 -- requirements
Module: wbs_ram16

Interface
REQ-001 Parameter ADDR_W, default 10: halfword address bits; memory holds 2**ADDR_W x 16 bits.
REQ-002 Parameter LATENCY, default 1, legal 1..4: edges from request acceptance to ack.
REQ-003 Parameter WAIT_STATES, default 0, legal 0..7: stall cycles inserted after each accepted request.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_ni  in  1  asynchronous, active-low reset.
REQ-006 wbsadr_i  in  64  byte address; bit 0 ignored; bits [ADDR_W:1] index memory.
REQ-007 wbsdat_i  in  16  write data.
REQ-008 wbswe_i  in  1  1=write, 0=read.
REQ-009 wbssel_i  in  2  lane select: bit0=[7:0], bit1=[15:8].
REQ-010 wbsstb_i  in  1  request strobe (B.4 pipelined).
REQ-011 wbscyc_i  in  1  bus cycle active.
REQ-012 wbsstall_o  out  1  request not accepted this cycle.
REQ-013 wbsack_o  out  1  one-cycle response strobe.
REQ-014 wbsdat_o  out  16  read data, valid with wbsack_o.
REQ-015 wbserr_o  out  1  error response (see Configuration).

Function
REQ-016 Request accepted on an edge where wbscyc_i & wbsstb_i & ~wbsstall_o.
REQ-017 Accepted write: memory lanes with wbssel_i bit set take wbsdat_i at the acceptance edge; other lane unchanged; sel=00 writes nothing but still acks.
REQ-018 Accepted read: full 16-bit word captured at acceptance edge; wbsdat_o carries both lanes regardless of wbssel_i.
REQ-019 Response: wbsack_o high exactly one cycle, in the cycle following edge (acceptance + LATENCY - 1); LATENCY=1 gives ack in cycle immediately after acceptance.
REQ-020 Responses return in acceptance order; one ack per accepted request; up to LATENCY requests in flight, held in a LATENCY-deep valid/data shift pipeline.
REQ-021 wbsdat_o holds last read value between acks; write acks leave wbsdat_o unchanged.
REQ-022 Stall counter: on acceptance loads WAIT_STATES; wbsstall_o = (counter != 0); decrements each edge to 0; WAIT_STATES=0 gives stall permanently 0 and one request per cycle.
REQ-023 Read one edge after a write to same address returns newly written data (no bypass hazard).
REQ-024 wbscyc_i low at an edge: all in-flight valid bits and stall counter cleared; no ack for abandoned requests; writes already committed remain.
REQ-025 wbsstb_i without wbscyc_i ignored.

Reset
REQ-026 reset_ni low asynchronously clears: wbsack_o=0, wbserr_o=0, wbsstall_o=0, wbsdat_o=16'h0000, pipeline valid bits, stall counter.
REQ-027 Memory contents not reset; reset mid-operation drops all in-flight responses.

Configuration
REQ-028 Macro WBS_RAM16_ERR_EN defined: access with any wbsadr_i[63:ADDR_W+1] nonzero performs no memory access and returns wbserr_o (not wbsack_o) with identical latency/ordering; wbsdat_o unchanged.
REQ-029 Macro undefined: upper address bits ignored (addresses alias modulo memory size); wbserr_o tied 0.

Structure
REQ-030 Shared package holds LATENCY/WAIT_STATES legal limits, lane-select constants (SEL_LO=2'b01, SEL_HI=2'b10, SEL_HW=2'b11), and bus width constants (ADR_W=64, DAT_W=16).
REQ-031 Memory array with per-lane write enable in one sub-module, wbs_ram16_mem; handshake, pipeline, stall counter in wbs_ram16.

Verification
REQ-032 LATENCY=1, WAIT=0: write 16'hBEEF sel=11 to 0x10, read 0x10 next cycle -> acks in consecutive cycles, read data 16'hBEEF.
REQ-033 Write 16'h1234 sel=11 to 0x20, then 16'h5656 sel=10 -> read 0x20 returns 16'h5634; sel=01 write of 16'h7878 -> 16'h5678.
REQ-034 LATENCY=3, four back-to-back reads of preloaded 0x0..0x6 -> four acks in consecutive cycles starting 3 cycles after first acceptance, data in order.
REQ-035 WAIT_STATES=2, stb held high for 3 requests -> stall pattern 0,1,1 repeating; acceptances every 3rd cycle; 3 acks total.
REQ-036 LATENCY=3, two reads accepted then wbscyc_i dropped -> no acks; reset_ni pulsed low mid-burst -> outputs zero immediately, no acks after release.
REQ-037 With WBS_RAM16_ERR_EN, ADDR_W=10, read address 0x800 -> wbserr_o one cycle, no ack; without macro, same read returns contents of 0x000.
